vga_sync_decoder: RTL and testbench

Recovers pixel position and timing lock from a VGA sync stream: the receiving end of the HSync/VSync/video signals produced by the VGA timing generator. It samples active-low HSync and VSync pulses and rebuilds the beam X/Y coordinates, one cycle behind the source. It checks every line length and every frame line count against the configured timing, and reports lock, errors and gated video. It sits on the same pixel clock as the generator, for loopback self-test or as the front end of a capture path.

---
 rtl/vga_sync_decoder.sv | 198 +++++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder
//   Rebuilds beam X/Y coordinates from an active-low HSync/VSync stream that
//   runs on the same pixel clock as the source. Coordinates trail the source
//   by one cycle. Each line length and each frame line count is checked
//   against the configured timing. Lock is declared after p_LOCK_FRAMES
//   consecutive good frames.
//
// Ports
//   i_Clk       pixel clock, all logic on the rising edge
//   i_Reset_n   asynchronous active-low reset
//   i_HSync     horizontal sync, active-low pulse
//   i_VSync     vertical sync, active-low pulse
//   i_Video     pixel data
//   o_X         recovered column, 0 until the first HSync fall
//   o_Y         recovered line, 0 until the first VSync fall
//   o_Visible   locked and inside the visible window (combinational)
//   o_Video     registered i_Video gated by o_Visible (combinational)
//   o_Locked    FSM is in LOCKED
//   o_Error     one-cycle pulse per cycle in which a violation is detected
//   o_ErrCount  violation count, saturating at 255
module vga_sync_decoder #(
    parameter int p_H_VISIBLE    = 640,
    parameter int p_H_PULSE_HEAD = 657,
    parameter int p_H_MAX        = 800,
    parameter int p_V_VISIBLE    = 480,
    parameter int p_V_PULSE_HEAD = 491,
    parameter int p_V_MAX        = 525,
    parameter int p_LOCK_FRAMES  = 2
) (
    input  logic       i_Clk,
    input  logic       i_Reset_n,
    input  logic       i_HSync,
    input  logic       i_VSync,
    input  logic       i_Video,
    output logic [9:0] o_X,
    output logic [9:0] o_Y,
    output logic       o_Visible,
    output logic       o_Video,
    output logic       o_Locked,
    output logic       o_Error,
    output logic [7:0] o_ErrCount
);

    localparam logic [9:0] c_H_VISIBLE    = 10'(p_H_VISIBLE);
    localparam logic [9:0] c_H_PULSE_HEAD = 10'(p_H_PULSE_HEAD);
    localparam logic [9:0] c_H_MAX        = 10'(p_H_MAX);
    localparam logic [9:0] c_H_OVER       = 10'(p_H_MAX + 1);
    localparam logic [9:0] c_V_VISIBLE    = 10'(p_V_VISIBLE);
    localparam logic [9:0] c_V_PULSE_HEAD = 10'(p_V_PULSE_HEAD);
    localparam logic [9:0] c_V_MAX        = 10'(p_V_MAX);
    localparam logic [9:0] c_V_OVER       = 10'(p_V_MAX + 1);
    localparam logic [3:0] c_LOCK_FRAMES  = 4'(p_LOCK_FRAMES);
    localparam logic [9:0] c_CNT_SAT      = 10'h3FF;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic [3:0] r_good;
    logic [3:0] w_next_good;

    logic       r_hs_q;
    logic       r_vs_q;
    logic       r_vid_q;
    logic [9:0] r_x;
    logic [9:0] r_y;
    logic [9:0] r_lc;
    logic [9:0] r_hc;
    logic       r_err;
    logic [7:0] r_err_count;

    logic       w_hs_fall;
    logic       w_vs_fall;
    logic       w_x_wrap;
    logic       w_viol;
    logic       w_err;

    assign w_hs_fall = r_hs_q & ~i_HSync;
    assign w_vs_fall = r_vs_q & ~i_VSync;

    // A fall reloads X, so the wrap only happens on a free-running cycle.
    assign w_x_wrap  = ~w_hs_fall && (r_x == c_H_MAX);

    // Counter values one past the maximum cover a missing pulse. When the
    // late pulse does arrive on that same cycle the terms overlap, which
    // still yields one violation.
    assign w_viol = (w_hs_fall && (r_lc != c_H_MAX)) ||
                    (r_lc == c_H_OVER) ||
                    (w_vs_fall && (r_hc != c_V_MAX)) ||
                    (r_hc == c_V_OVER);

    assign w_err = w_viol && (r_state != SEARCH);

    // Sampling, beam coordinates and line/frame length counters run in every
    // state so that checking can start immediately on entering VERIFY.
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_hs_q  <= 1'b1;
            r_vs_q  <= 1'b1;
            r_vid_q <= 1'b0;
            r_x     <= '0;
            r_y     <= '0;
            r_lc    <= '0;
            r_hc    <= '0;
        end else begin
            r_hs_q  <= i_HSync;
            r_vs_q  <= i_VSync;
            r_vid_q <= i_Video;

            if (w_hs_fall) begin
                r_x <= c_H_PULSE_HEAD;
            end else if (r_x != '0) begin
                r_x <= w_x_wrap ? 10'd1 : r_x + 10'd1;
            end

            // VSync fall wins over a coincident line wrap.
            if (w_vs_fall) begin
                r_y <= c_V_PULSE_HEAD;
            end else if ((r_y != '0) && w_x_wrap) begin
                r_y <= (r_y == c_V_MAX) ? 10'd1 : r_y + 10'd1;
            end

            if (w_hs_fall) begin
                r_lc <= 10'd1;
            end else if (r_lc != c_CNT_SAT) begin
                r_lc <= r_lc + 10'd1;
            end

            if (w_vs_fall) begin
                r_hc <= '0;
            end else if (w_hs_fall && (r_hc != c_CNT_SAT)) begin
                r_hc <= r_hc + 10'd1;
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_state     <= SEARCH;
            r_good      <= '0;
            r_err       <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_state <= w_next_state;
            r_good  <= w_next_good;
            r_err   <= w_err;
            if (w_err && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_good  = r_good;
        case (r_state)
            SEARCH: begin
                if (w_vs_fall) begin
                    w_next_state = VERIFY;
                    w_next_good  = '0;
                end
            end
            VERIFY: begin
                if (w_viol) begin
                    w_next_state = SEARCH;
                end else if (w_vs_fall) begin
                    w_next_good = r_good + 4'd1;
                    if ((r_good + 4'd1) >= c_LOCK_FRAMES) begin
                        w_next_state = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (w_viol) begin
                    w_next_state = SEARCH;
                end
            end
            default: begin
                w_next_state = SEARCH;
            end
        endcase
    end

    assign o_X        = r_x;
    assign o_Y        = r_y;
    assign o_Locked   = (r_state == LOCKED);
    assign o_Error    = r_err;
    assign o_ErrCount = r_err_count;
    assign o_Visible  = o_Locked &&
                        (r_x != '0) && (r_x <= c_H_VISIBLE) &&
                        (r_y != '0) && (r_y <= c_V_VISIBLE);
    assign o_Video    = r_vid_q & o_Visible;

endmodule

// File: tb/tb_vga_sync_decoder.sv
module tb_vga_sync_decoder;

  // Reduced timing so several full frames fit in a short run.
  localparam int H_VIS = 8;
  localparam int H_PH  = 10;
  localparam int H_PW  = 2;
  localparam int H_MAX = 14;
  localparam int V_VIS = 4;
  localparam int V_PH  = 6;
  localparam int V_PW  = 2;
  localparam int V_MAX = 8;
  localparam int LOCK  = 2;
  localparam int FRAME = H_MAX * V_MAX;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       i_Reset_n;
  logic       i_HSync;
  logic       i_VSync;
  logic       i_Video;
  logic [9:0] o_X;
  logic [9:0] o_Y;
  logic       o_Visible;
  logic       o_Video;
  logic       o_Locked;
  logic       o_Error;
  logic [7:0] o_ErrCount;

  vga_sync_decoder #(
    .p_H_VISIBLE    (H_VIS),
    .p_H_PULSE_HEAD (H_PH),
    .p_H_MAX        (H_MAX),
    .p_V_VISIBLE    (V_VIS),
    .p_V_PULSE_HEAD (V_PH),
    .p_V_MAX        (V_MAX),
    .p_LOCK_FRAMES  (LOCK)
  ) dut (
    .i_Clk      (clk),
    .i_Reset_n  (i_Reset_n),
    .i_HSync    (i_HSync),
    .i_VSync    (i_VSync),
    .i_Video    (i_Video),
    .o_X        (o_X),
    .o_Y        (o_Y),
    .o_Visible  (o_Visible),
    .o_Video    (o_Video),
    .o_Locked   (o_Locked),
    .o_Error    (o_Error),
    .o_ErrCount (o_ErrCount)
  );

  // ---------------- scoreboard counters ----------------
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // ---------------- source generator model ----------------
  int gx, gy, cur_len;
  bit supp_arm, stretch_arm, extra_arm;
  int supp_y, stretch_y;
  bit vid_drive;
  int p_x, p_y;
  bit p_hs_fall, p_vs_fall;
  bit last_hs, last_vs;
  bit x_acq, y_acq;
  int n_vs;

  task automatic gen_init();
    gx = 1; gy = 1; cur_len = H_MAX;
    supp_arm = 0; stretch_arm = 0; extra_arm = 0;
    last_hs = 1; last_vs = 1; x_acq = 0; y_acq = 0; n_vs = 0;
  endtask

  // Drive one source pixel, let the DUT sample it, then advance the source.
  task automatic gen_step();
    logic hs, vs;
    hs = !(gx >= H_PH && gx < H_PH + H_PW);
    if (supp_arm && gy == supp_y) hs = 1'b1;
    vs = !(gy >= V_PH && gy < V_PH + V_PW);
    i_HSync = hs; i_VSync = vs; i_Video = vid_drive;
    @(posedge clk); #1;
    p_x = gx; p_y = gy;
    p_hs_fall = last_hs && !hs;
    p_vs_fall = last_vs && !vs;
    last_hs = hs; last_vs = vs;
    if (p_hs_fall) x_acq = 1;
    if (p_vs_fall) begin y_acq = 1; n_vs++; end
    if (gx >= cur_len) begin
      gx = 1;
      if (supp_arm && gy == supp_y) supp_arm = 0;
      if (gy == V_MAX && extra_arm) begin gy = V_MAX + 1; extra_arm = 0; end
      else if (gy >= V_MAX) gy = 1;
      else gy++;
      cur_len = H_MAX;
      if (stretch_arm && gy == stretch_y) begin cur_len = H_MAX + 1; stretch_arm = 0; end
    end else begin
      gx++;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic hs, input logic vs);
    i_HSync = hs; i_VSync = vs; i_Video = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    i_HSync = 1'b1; i_VSync = 1'b1; i_Video = 1'b0;
    i_Reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 i_Reset_n = 1'b1;
  endtask

  task automatic step_until_gy(input int y);
    int cyc = 0;
    while (gy != y && cyc < 300) begin gen_step(); cyc++; end
  endtask

  task automatic step_until_pos(input int x, input int y);
    int cyc = 0;
    while (!(gx == x && gy == y) && cyc < 300) begin gen_step(); cyc++; end
  endtask

  task automatic wait_lock(input string name);
    int cyc = 0;
    while (o_Locked !== 1'b1 && cyc < 800) begin gen_step(); cyc++; end
    check(name, int'(o_Locked), 1);
  endtask

  task automatic wait_err(output int ex, output int ey, output int early);
    int cyc = 0;
    ex = -1; ey = -1; early = 0;
    while (cyc < 400) begin
      gen_step(); cyc++;
      if (o_Error === 1'b1) begin ex = p_x; ey = p_y; break; end
      if (o_Locked !== 1'b1) early++;
    end
  endtask

  // ---------------- reset-sequence vectors ----------------
  typedef struct {
    logic hs;
    logic vs;
    int   x;
    int   y;
    logic lock;
    logic err;
    int   cnt;
  } vec_t;

  vec_t vecs[15];

  initial begin
    int ex, ey, early, n, cyc, after;
    int lock_bad, xy_bad, vid_bad, err_bad, vid_cnt, unl_vid, zero_bad;
    int pulses, cnt_bad, exp_cnt;
    logic exp_lock, exp_vis;

    // hs vs | x y lock err cnt
    vecs[0]  = '{1'b1, 1'b1, 0,  0, 1'b0, 1'b0, 0};
    vecs[1]  = '{1'b0, 1'b1, 10, 0, 1'b0, 1'b0, 0};  // first HSync fall loads X
    vecs[2]  = '{1'b0, 1'b1, 11, 0, 1'b0, 1'b0, 0};  // still low: no reload
    vecs[3]  = '{1'b1, 1'b1, 12, 0, 1'b0, 1'b0, 0};
    vecs[4]  = '{1'b1, 1'b1, 13, 0, 1'b0, 1'b0, 0};
    vecs[5]  = '{1'b1, 1'b1, 14, 0, 1'b0, 1'b0, 0};
    vecs[6]  = '{1'b1, 1'b0, 1,  6, 1'b0, 1'b0, 0};  // X wraps, VSync load wins
    vecs[7]  = '{1'b1, 1'b0, 2,  6, 1'b0, 1'b0, 0};
    vecs[8]  = '{1'b1, 1'b1, 3,  6, 1'b0, 1'b0, 0};
    vecs[9]  = '{1'b0, 1'b1, 10, 6, 1'b0, 1'b1, 1};  // short line in VERIFY
    vecs[10] = '{1'b0, 1'b1, 11, 6, 1'b0, 1'b0, 1};
    vecs[11] = '{1'b1, 1'b1, 12, 6, 1'b0, 1'b0, 1};
    vecs[12] = '{1'b1, 1'b1, 13, 6, 1'b0, 1'b0, 1};
    vecs[13] = '{1'b1, 1'b1, 14, 6, 1'b0, 1'b0, 1};
    vecs[14] = '{1'b1, 1'b1, 1,  7, 1'b0, 1'b0, 1};  // wrap advances Y

    vid_drive = 1'b0;
    i_Reset_n = 1'b1;
    gen_init();

    // ---- reset state ----
    do_reset();
    check("reset_x", int'(o_X), 0);
    check("reset_y", int'(o_Y), 0);
    check("reset_locked", int'(o_Locked), 0);
    check("reset_error", int'(o_Error), 0);
    check("reset_errcount", int'(o_ErrCount), 0);
    check("reset_video", int'({o_Visible, o_Video}), 0);

    // ---- vector table ----
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].hs, vecs[i].vs);
      check($sformatf("vec%0d_x_y_lock_err_cnt", i),
            int'({o_X, o_Y, o_Locked, o_Error, o_ErrCount}),
            int'({10'(vecs[i].x), 10'(vecs[i].y), vecs[i].lock, vecs[i].err, 8'(vecs[i].cnt)}));
    end

    // ---- clean loopback from reset: lock on 3rd VSync fall, track 3 frames ----
    do_reset();
    gen_init();
    vid_drive = 1'b1;
    lock_bad = 0; xy_bad = 0; vid_bad = 0; err_bad = 0; vid_cnt = 0; unl_vid = 0;
    after = 0; cyc = 0;
    while (after < 3 * FRAME && cyc < 1500) begin
      gen_step(); cyc++;
      exp_lock = (n_vs >= 3);
      exp_vis = exp_lock && p_x >= 1 && p_x <= H_VIS && p_y >= 1 && p_y <= V_VIS;
      if (o_Locked !== exp_lock) lock_bad++;
      if (o_X !== 10'(x_acq ? p_x : 0) || o_Y !== 10'(y_acq ? p_y : 0)) xy_bad++;
      if (o_Visible !== exp_vis || o_Video !== (exp_vis && vid_drive)) vid_bad++;
      if (o_Error !== 1'b0 || o_ErrCount !== 8'd0) err_bad++;
      if (exp_lock) begin
        after++;
        if (o_Video === 1'b1) vid_cnt++;
      end else if (o_Video !== 1'b0) begin
        unl_vid++;
      end
    end
    check("loop_frames_run", after, 3 * FRAME);
    check("loop_lock_timing", lock_bad, 0);
    check("loop_xy_track", xy_bad, 0);
    check("loop_video_gate", vid_bad, 0);
    check("loop_video_per_3_frames", vid_cnt, 3 * H_VIS * V_VIS);
    check("loop_video_unlocked", unl_vid, 0);
    check("loop_no_error", err_bad, 0);

    // ---- missing HSync pulse on line 3 ----
    step_until_gy(7);
    check("locked_before_miss", int'(o_Locked), 1);
    supp_y = 3; supp_arm = 1;
    wait_err(ex, ey, early);
    check("miss_err_x", ex, H_PH + 1);
    check("miss_err_y", ey, 3);
    check("miss_errcount", int'(o_ErrCount), 1);
    check("miss_unlock", int'(o_Locked), 0);
    check("miss_lock_held_until_err", early, 0);
    n = 0; cyc = 0;
    while (o_Locked !== 1'b1 && cyc < 600) begin
      gen_step(); cyc++;
      if (p_vs_fall) n++;
    end
    check("relock_vsync_falls", n, 3);
    check("relock_errcount", int'(o_ErrCount), 1);

    // ---- asynchronous reset mid-line while locked ----
    step_until_pos(4, 2);
    check("pre_reset_video", int'(o_Video), 1);
    i_Reset_n = 1'b0;
    #1;
    check("arst_x", int'(o_X), 0);
    check("arst_y", int'(o_Y), 0);
    check("arst_locked", int'(o_Locked), 0);
    check("arst_errcount", int'(o_ErrCount), 0);
    check("arst_video", int'({o_Visible, o_Video}), 0);
    gen_step();
    gen_step();
    last_hs = 1; last_vs = 1; x_acq = 0; y_acq = 0; n_vs = 0;
    i_Reset_n = 1'b1;
    zero_bad = 0; cyc = 0;
    do begin
      gen_step(); cyc++;
      if (!p_hs_fall && o_X !== 10'd0) zero_bad++;
    end while (!p_hs_fall && cyc < 100);
    check("rst_x_hold_zero", zero_bad, 0);
    check("rst_x_reload", int'(o_X), H_PH);

    // ---- stretched line (line 2 is H_MAX+1 clocks) ----
    wait_lock("lock_after_reset");
    step_until_gy(7);
    stretch_y = 2; stretch_arm = 1;
    wait_err(ex, ey, early);
    check("stretch_err_x", ex, H_PH);
    check("stretch_err_y", ey, 3);
    check("stretch_errcount", int'(o_ErrCount), 1);
    check("stretch_unlock", int'(o_Locked), 0);
    check("stretch_lock_held_until_err", early, 0);

    // ---- frame with one extra line ----
    wait_lock("lock_before_extra");
    step_until_gy(7);
    extra_arm = 1;
    wait_err(ex, ey, early);
    check("extra_err_x", ex, H_PH + 1);
    check("extra_err_y", ey, 5);
    check("extra_errcount", int'(o_ErrCount), 2);
    check("extra_unlock", int'(o_Locked), 0);

    // ---- error counter saturation ----
    do_reset();
    drive(1'b1, 1'b1);
    pulses = 0; cnt_bad = 0;
    for (int i = 1; i <= 260; i++) begin
      drive(1'b1, 1'b0);   // VSync fall: enter VERIFY
      drive(1'b0, 1'b1);   // short line: violation
      if (o_Error === 1'b1) pulses++;
      exp_cnt = (i > 255) ? 255 : i;
      if (o_ErrCount !== 8'(exp_cnt)) cnt_bad++;
      drive(1'b1, 1'b1);
    end
    check("sat_error_pulses", pulses, 260);
    check("sat_count_track", cnt_bad, 0);
    check("sat_final_count", int'(o_ErrCount), 255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
